conv_kernel_scheduler: RTL and testbench

//  Streams kernel weights and biases from a 1-cycle-latency weight memory into the

---
 rtl/conv_kernel_scheduler_if.sv | 26 ++
 rtl/conv_kernel_scheduler.sv | 154 +++++++++++++++
 tb/tb_conv_kernel_scheduler.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/conv_kernel_scheduler_if.sv
// Weight-memory read port plus kernel/bias delivery bus between scheduler and convolution core.
// The master side is the scheduler. It issues reads and presents kernels. The slave side returns read data and hold.
interface conv_kernel_scheduler_if #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int N_CHANNELS  = 32,
  parameter int KERNEL_SIZE = 3
);
  logic                                                    mem_rd_o;
  logic [ADDR_WIDTH-1:0]                                   mem_addr_o;
  logic [DATA_WIDTH-1:0]                                   mem_data_i;
  logic [N_CHANNELS*KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] kernel_o;
  logic [N_CHANNELS-1:0]                                   kernel_valid_o;
  logic [N_CHANNELS-1:0]                                   hold_kernel_i;
  logic [DATA_WIDTH-1:0]                                   bias_o;

  modport master (
    output mem_rd_o, mem_addr_o, kernel_o, kernel_valid_o, bias_o,
    input  mem_data_i, hold_kernel_i
  );

  modport slave (
    input  mem_rd_o, mem_addr_o, kernel_o, kernel_valid_o, bias_o,
    output mem_data_i, hold_kernel_i
  );
endinterface

// File: rtl/conv_kernel_scheduler.sv
// Replays all kernel slots and biases from weight memory into the conv core once per output window.
// A slot load takes K*K+1 cycles. The scheduler stalls while the target slot (or, for a new bias, any slot) is still unconsumed.
module conv_kernel_scheduler #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int N_ROWS      = 28,
  parameter int N_COLS      = 28,
  parameter int N_CHANNELS  = 32,
  parameter int N_KERNELS   = 32,
  parameter int KERNEL_SIZE = 3,
  parameter int W_BASE      = 0,
  parameter int B_BASE      = 'h4800
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic start_i,
  output logic busy_o,
  output logic done_o,
  conv_kernel_scheduler_if.master bus
);
  localparam int KK    = KERNEL_SIZE * KERNEL_SIZE;
  localparam int N_WIN = (N_ROWS - KERNEL_SIZE + 1) * (N_COLS - KERNEL_SIZE + 1);
  localparam int KW    = (N_KERNELS > 1) ? $clog2(N_KERNELS) : 1;
  localparam int CW    = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
  localparam int TW    = (KK > 1) ? $clog2(KK) : 1;
  localparam int WW    = (N_WIN > 1) ? $clog2(N_WIN) : 1;
  localparam int SW    = (N_CHANNELS * KK > 1) ? $clog2(N_CHANNELS * KK) : 1;

  typedef enum logic [2:0] {
    IDLE, WAIT_DRAIN, FETCH_BIAS, WAIT_SLOT, FETCH_W, ADVANCE, FINISH
  } state_t;

  state_t                              state_q, state_d;
  logic [KW-1:0]                       kern_q;
  logic [CW-1:0]                       chan_q;
  logic [TW-1:0]                       tap_q;
  logic [WW-1:0]                       win_q;
  logic                                busy_q;
  logic [N_CHANNELS-1:0]               kv_q, hs_q;
  logic [N_CHANNELS*KK-1:0][DATA_WIDTH-1:0] kernel_q;
  logic [DATA_WIDTH-1:0]               bias_q;
  logic                                bias_pend_q, wr_pend_q;
  logic [SW-1:0]                       wr_idx_q;
  logic                                chan_last, kern_last, win_last;

  assign chan_last = (chan_q == CW'(N_CHANNELS - 1));
  assign kern_last = (kern_q == KW'(N_KERNELS - 1));
  assign win_last  = (win_q  == WW'(N_WIN - 1));

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (start_i) state_d = WAIT_DRAIN;
      WAIT_DRAIN: if (kv_q == '0) state_d = FETCH_BIAS;
      FETCH_BIAS: state_d = WAIT_SLOT;
      WAIT_SLOT:  if (!kv_q[chan_q]) state_d = FETCH_W;
      FETCH_W:    if (tap_q == TW'(KK - 1)) state_d = ADVANCE;
      ADVANCE: begin
        if (!chan_last)                         state_d = WAIT_SLOT;
        else if (!kern_last || !win_last)       state_d = WAIT_DRAIN;
        else                                    state_d = FINISH;
      end
      FINISH:     if (kv_q == '0) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_rd_o   = 1'b0;
    bus.mem_addr_o = '0;
    done_o         = 1'b0;
    case (state_q)
      FETCH_BIAS: begin
        bus.mem_rd_o   = 1'b1;
        bus.mem_addr_o = ADDR_WIDTH'(B_BASE + int'(kern_q));
      end
      FETCH_W: begin
        bus.mem_rd_o   = 1'b1;
        bus.mem_addr_o = ADDR_WIDTH'(W_BASE + (int'(kern_q) * N_CHANNELS + int'(chan_q)) * KK
                                     + int'(tap_q));
      end
      FINISH:  done_o = (kv_q == '0);
      default: ;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      kern_q      <= '0;
      chan_q      <= '0;
      tap_q       <= '0;
      win_q       <= '0;
      busy_q      <= 1'b0;
      kv_q        <= '0;
      hs_q        <= '0;
      kernel_q    <= '0;
      bias_q      <= '0;
      bias_pend_q <= 1'b0;
      wr_pend_q   <= 1'b0;
      wr_idx_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (start_i) begin
          busy_q <= 1'b1;
          kern_q <= '0;
          chan_q <= '0;
          win_q  <= '0;
        end
        WAIT_SLOT: tap_q <= '0;
        FETCH_W:   tap_q <= tap_q + TW'(1);
        ADVANCE: begin
          if (!chan_last) chan_q <= chan_q + CW'(1);
          else begin
            chan_q <= '0;
            if (!kern_last) kern_q <= kern_q + KW'(1);
            else begin
              kern_q <= '0;
              win_q  <= win_last ? '0 : win_q + WW'(1);
            end
          end
        end
        FINISH: if (kv_q == '0) busy_q <= 1'b0;
        default: ;
      endcase

      // Memory returns data one cycle after the read, so writes trail the read strobe by one stage.
      bias_pend_q <= (state_q == FETCH_BIAS);
      if (bias_pend_q) bias_q <= bus.mem_data_i;
      wr_pend_q <= (state_q == FETCH_W);
      wr_idx_q  <= SW'(int'(chan_q) * KK + int'(tap_q));
      if (wr_pend_q) kernel_q[wr_idx_q] <= bus.mem_data_i;

      // A slot counts as consumed once the core has raised and then dropped hold on it.
      for (int i = 0; i < N_CHANNELS; i++) begin
        if (kv_q[i] && bus.hold_kernel_i[i]) hs_q[i] <= 1'b1;
        if (hs_q[i] && !bus.hold_kernel_i[i]) begin
          kv_q[i] <= 1'b0;
          hs_q[i] <= 1'b0;
        end
      end
      if (state_q == ADVANCE) kv_q[chan_q] <= 1'b1;
    end
  end

  assign busy_o             = busy_q;
  assign bus.kernel_o       = kernel_q;
  assign bus.kernel_valid_o = kv_q;
  assign bus.bias_o         = bias_q;
endmodule

// File: tb/tb_conv_kernel_scheduler.sv
// Directed bench with memory and core responders; slot loads are scored against a queue of expected loads.
module tb_conv_kernel_scheduler;
  localparam int AW = 16, DW = 32, NR = 4, NC = 4, NCH = 2, NK = 2, K = 3;
  localparam int KK = K * K, NWIN = (NR - K + 1) * (NC - K + 1);
  localparam int B_BASE = 'h4800, NLOADS = NWIN * NK * NCH;
  localparam int CWID = NCH * KK * DW;

  typedef struct {
    int slot;
    int base;
    int bias;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic busy, done;
  bit   stall1 = 1'b0;
  int   n_cmp = 0, n_err = 0;
  int   cyc = 0, fetch_cyc = 0, n_loads = 0, n_done = 0;
  exp_t sb[$];

  logic [NCH-1:0]        prev_kv;
  logic [DW-1:0]         prev_bias;
  logic                  wread_prev;
  int                    age[NCH];
  bit                    drop[NCH];
  logic [KK*DW-1:0]      snap[NCH];
  logic [DW-1:0]         snapb[NCH];

  conv_kernel_scheduler_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_CHANNELS(NCH), .KERNEL_SIZE(K)) bus ();

  conv_kernel_scheduler #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_ROWS(NR), .N_COLS(NC), .N_CHANNELS(NCH),
    .N_KERNELS(NK), .KERNEL_SIZE(K), .W_BASE(0), .B_BASE(B_BASE)
  ) u_dut (
    .clock_i(clk), .reset_i(rst_n), .start_i(start), .busy_o(busy), .done_o(done), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [CWID-1:0] obs, input logic [CWID-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Weight memory: mem[a] = a, one-cycle read latency.
  always @(posedge clk) if (bus.mem_rd_o) bus.mem_data_i <= DW'(bus.mem_addr_o);

  // Core model and scoreboard consumer, sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      prev_kv = '0;
      prev_bias = '0;
      wread_prev = 1'b0;
      bus.hold_kernel_i = '0;
      for (int c = 0; c < NCH; c++) begin
        age[c] = 0;
        drop[c] = 1'b0;
      end
    end else begin
      if (bus.mem_rd_o && int'(bus.mem_addr_o) < B_BASE && !wread_prev) fetch_cyc = cyc;
      wread_prev = bus.mem_rd_o && int'(bus.mem_addr_o) < B_BASE;
      if (done) n_done++;
      if (bus.bias_o != prev_bias) chk("bias_change_idle", CWID'(bus.kernel_valid_o), '0);
      for (int c = 0; c < NCH; c++) begin
        if (drop[c]) begin
          drop[c] = 1'b0;
          chk("consume_clear", CWID'(bus.kernel_valid_o[c]), '0);
          chk("slot_stable", CWID'(bus.kernel_o[c*KK*DW +: KK*DW]), CWID'(snap[c]));
          chk("bias_stable", CWID'(bus.bias_o), CWID'(snapb[c]));
        end
        if (bus.kernel_valid_o[c] && !prev_kv[c]) begin
          logic [KK*DW-1:0] e_taps;
          n_loads++;
          age[c] = 0;
          snap[c] = bus.kernel_o[c*KK*DW +: KK*DW];
          snapb[c] = bus.bias_o;
          if (sb.size() == 0) chk("sb_unexpected_load", CWID'(n_loads), '0);
          else begin
            exp_t e;
            e = sb.pop_front();
            for (int t = 0; t < KK; t++) e_taps[t*DW +: DW] = DW'(e.base + t);
            chk("load_slot", CWID'(c), CWID'(e.slot));
            chk("load_taps", CWID'(snap[c]), CWID'(e_taps));
            chk("load_bias", CWID'(bus.bias_o), CWID'(e.bias));
            chk("load_latency", CWID'(cyc - fetch_cyc), CWID'(KK + 1));
          end
        end else if (bus.kernel_valid_o[c]) begin
          age[c]++;
          if (age[c] == 2) bus.hold_kernel_i[c] = 1'b1;
          if (age[c] >= 7 && bus.hold_kernel_i[c] && !(c == 1 && stall1)) begin
            bus.hold_kernel_i[c] = 1'b0;
            drop[c] = 1'b1;
          end
        end
      end
      prev_kv = bus.kernel_valid_o;
      prev_bias = bus.bias_o;
    end
  end

  task automatic push_map();
    exp_t e;
    for (int w = 0; w < NWIN; w++)
      for (int k = 0; k < NK; k++)
        for (int c = 0; c < NCH; c++) begin
          e.slot = c;
          e.base = (k * NCH + c) * KK;
          e.bias = B_BASE + k;
          sb.push_back(e);
        end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"},  CWID'(busy), '0);
    chk({tag, "_done"},  CWID'(done), '0);
    chk({tag, "_rd"},    CWID'(bus.mem_rd_o), '0);
    chk({tag, "_addr"},  CWID'(bus.mem_addr_o), '0);
    chk({tag, "_valid"}, CWID'(bus.kernel_valid_o), '0);
    chk({tag, "_kernel"}, bus.kernel_o, '0);
    chk({tag, "_bias"},  CWID'(bus.bias_o), '0);
  endtask

  initial begin
    logic [CWID-1:0] k_snap;
    logic [DW-1:0]   b_snap;
    int rd_cnt, done_before;
    bit ok;

    // Reset state
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Full map, slot 1 held to force a stall in the drain wait
    stall1 = 1'b1;
    push_map();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("busy_after_start", CWID'(busy), CWID'(1));
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (n_loads >= 2 && bus.kernel_valid_o == 2'b10) begin ok = 1'b1; break; end
    end
    chk("stall_reached", CWID'(ok), CWID'(1));
    k_snap = bus.kernel_o;
    b_snap = bus.bias_o;
    rd_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      start = (i == 5);
      if (bus.mem_rd_o) rd_cnt++;
    end
    start = 1'b0;
    chk("stall_no_reads", CWID'(rd_cnt), '0);
    chk("stall_kernel_stable", bus.kernel_o, k_snap);
    chk("stall_bias_stable", CWID'(bus.bias_o), CWID'(b_snap));
    chk("stall_valid", CWID'(bus.kernel_valid_o), CWID'(2'b10));
    chk("stall_loads", CWID'(n_loads), CWID'(2));
    stall1 = 1'b0;

    ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (n_done > 0) begin ok = 1'b1; break; end
    end
    chk("done_reached", CWID'(ok), CWID'(1));
    repeat (2) @(negedge clk);
    chk("busy_low_after_done", CWID'(busy), '0);
    repeat (50) @(negedge clk);
    chk("single_done", CWID'(n_done), CWID'(1));
    chk("total_loads", CWID'(n_loads), CWID'(NLOADS));
    chk("sb_drained", CWID'(sb.size()), '0);

    // Reset in the middle of a weight fetch
    push_map();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (n_loads > NLOADS && bus.mem_rd_o && int'(bus.mem_addr_o) < B_BASE) begin ok = 1'b1; break; end
    end
    chk("fetch_w_reached", CWID'(ok), CWID'(1));
    done_before = n_done;
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    sb.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("no_done_after_reset", CWID'(n_done), CWID'(done_before));
    chk("idle_after_reset", CWID'(busy), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
